trade_history: RTL and testbench



---
 rtl/trade_history.sv | 124 ++++++++++++
 tb/tb_trade_history.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trade_history.sv
// Samples the latest trade price every SAMPLE_DIV clocks into a DEPTH-entry ring buffer, read oldest-first.
// Define TRADE_HISTORY_MINMAX_EN to track the min/max of every sample written since reset.
module trade_history #(
  parameter int DEPTH      = 64,
  parameter int AW         = 6,
  parameter int SAMPLE_DIV = 50000
) (
  input  logic          clk_50,
  input  logic          reset_n,
  input  logic          match_signal,
  input  logic [7:0]    trade_price,
  input  logic          halt_signal,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic [AW:0]   sample_count,
  output logic          full,
  output logic [7:0]    last_price,
  output logic          new_sample,
  output logic [7:0]    min_price,
  output logic [7:0]    max_price
);

  localparam int            CW         = $clog2(SAMPLE_DIV);
  localparam logic [CW-1:0] TICK_LAST  = CW'(SAMPLE_DIV - 1);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);

  logic [CW-1:0] tick_cnt;
  logic [AW-1:0] wr_ptr;
  logic [7:0]    pending;
  logic          pending_valid;
  logic          have_price;
  logic [7:0]    mem [DEPTH];

  logic          tick;
  logic          write_en;
  logic [7:0]    write_value;
  logic [AW-1:0] rd_phys;
  logic          rd_in_range;

  // A trade in the tick cycle itself wins over anything older that is still pending.
  assign tick        = (tick_cnt == TICK_LAST) && !halt_signal;
  assign write_en    = tick && (have_price || match_signal);
  assign write_value = match_signal  ? trade_price :
                       pending_valid ? pending     : last_price;

  assign full        = (sample_count == FULL_COUNT);
  assign rd_phys     = (full ? wr_ptr : '0) + rd_addr;
  assign rd_in_range = {1'b0, rd_addr} < sample_count;

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else if (!halt_signal) begin
      tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      pending       <= 8'h00;
      pending_valid <= 1'b0;
      have_price    <= 1'b0;
    end else begin
      if (match_signal) begin
        pending    <= trade_price;
        have_price <= 1'b1;
      end
      if (write_en) begin
        pending_valid <= 1'b0;
      end else if (match_signal) begin
        pending_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      sample_count <= '0;
      last_price   <= 8'h00;
      new_sample   <= 1'b0;
    end else begin
      new_sample <= write_en;
      if (write_en) begin
        wr_ptr     <= wr_ptr + AW'(1);
        last_price <= write_value;
        if (!full) begin
          sample_count <= sample_count + (AW+1)'(1);
        end
      end
    end
  end

  // Storage is deliberately left uncleared; sample_count decides what is valid.
  always_ff @(posedge clk_50) begin
    if (write_en) begin
      mem[wr_ptr] <= write_value;
    end
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= 8'h00;
    end else begin
      rd_data <= rd_in_range ? mem[rd_phys] : 8'h00;
    end
  end

`ifdef TRADE_HISTORY_MINMAX_EN
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      min_price <= 8'hFF;
      max_price <= 8'h00;
    end else if (write_en) begin
      if (write_value < min_price) min_price <= write_value;
      if (write_value > max_price) max_price <= write_value;
    end
  end
`else
  assign min_price = 8'h00;
  assign max_price = 8'h00;
`endif

endmodule

// File: tb/tb_trade_history.sv
// Randomised self-checking bench for trade_history against a queue-based history model.
module tb_trade_history;

  localparam int DEPTH      = 4;
  localparam int AW         = 2;
  localparam int SAMPLE_DIV = 4;

  logic          clk_50;
  logic          reset_n;
  logic          match_signal;
  logic [7:0]    trade_price;
  logic          halt_signal;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic [AW:0]   sample_count;
  logic          full;
  logic [7:0]    last_price;
  logic          new_sample;
  logic [7:0]    min_price;
  logic [7:0]    max_price;

  trade_history #(.DEPTH(DEPTH), .AW(AW), .SAMPLE_DIV(SAMPLE_DIV)) dut (
    .clk_50(clk_50),
    .reset_n(reset_n),
    .match_signal(match_signal),
    .trade_price(trade_price),
    .halt_signal(halt_signal),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .sample_count(sample_count),
    .full(full),
    .last_price(last_price),
    .new_sample(new_sample),
    .min_price(min_price),
    .max_price(max_price)
  );

  initial clk_50 = 1'b0;
  always #5 clk_50 = ~clk_50;

  int total_cnt = 0;
  int pass_cnt  = 0;

  // Reference model: history is an oldest-first queue trimmed to DEPTH entries.
  logic [7:0] hist [$];
  logic [7:0] m_last, m_pend, m_min, m_max, exp_rd;
  bit         m_pend_v, m_have, exp_new;
  int         phase;

  function automatic void model_reset();
    hist.delete();
    m_last = 8'h00; m_pend = 8'h00; m_min = 8'hFF; m_max = 8'h00;
    exp_rd = 8'h00; m_pend_v = 1'b0; m_have = 1'b0; exp_new = 1'b0;
    phase = 0;
  endfunction

  function automatic void model_step(bit m, logic [7:0] p, bit h, logic [AW-1:0] a);
    bit wr;
    logic [7:0] v;
    exp_rd  = (int'(a) < hist.size()) ? hist[a] : 8'h00;
    wr      = !h && (phase % SAMPLE_DIV == SAMPLE_DIV - 1) && (m_have || m);
    exp_new = wr;
    if (wr) begin
      v = m ? p : (m_pend_v ? m_pend : m_last);
      hist.push_back(v);
      if (hist.size() > DEPTH) void'(hist.pop_front());
      m_last = v;
      if (v < m_min) m_min = v;
      if (v > m_max) m_max = v;
      m_pend_v = 1'b0;
    end else if (m) begin
      m_pend_v = 1'b1;
    end
    if (m) begin
      m_pend = p;
      m_have = 1'b1;
    end
    if (!h) phase++;
  endfunction

  function automatic logic [7:0] want_min();
`ifdef TRADE_HISTORY_MINMAX_EN
    return m_min;
`else
    return 8'h00;
`endif
  endfunction

  function automatic logic [7:0] want_max();
`ifdef TRADE_HISTORY_MINMAX_EN
    return m_max;
`else
    return 8'h00;
`endif
  endfunction

  function automatic logic [36:0] got_vec();
    return {rd_data, sample_count, full, last_price, new_sample, min_price, max_price};
  endfunction

  function automatic logic [36:0] want_vec();
    return {exp_rd, 3'(hist.size()), hist.size() == DEPTH, m_last, exp_new, want_min(), want_max()};
  endfunction

  // Called at a falling edge; drives one cycle and returns at the next falling edge.
  task automatic step(input bit m, input logic [7:0] p, input bit h, input logic [AW-1:0] a);
    match_signal = m;
    trade_price  = p;
    halt_signal  = h;
    rd_addr      = a;
    model_step(m, p, h, a);
    @(posedge clk_50);
    @(negedge clk_50);
  endtask

  task automatic align_interval();
    while (phase % SAMPLE_DIV != 0) step(1'b0, 8'(($urandom)), 1'b0, 2'($urandom_range(0, 3)));
  endtask

  task automatic test_reset();
    @(negedge clk_50);
    #2 reset_n = 1'b0;
    match_signal = 1'b0; halt_signal = 1'b0; trade_price = 8'h00; rd_addr = '0;
    #1 model_reset();
    total_cnt++;
    if (got_vec() !== want_vec()) $display("[TB] FAIL reset_state: got %h, expected %h", got_vec(), want_vec());
    else pass_cnt++;
    @(negedge clk_50);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 8'($urandom), 1'b0, 2'($urandom_range(0, 3)));
      total_cnt++;
      if ({rd_data, sample_count, new_sample} !== 12'h000)
        $display("[TB] FAIL idle_outputs: got rd=%h cnt=%0d new=%b, expected all 0", rd_data, sample_count, new_sample);
      else pass_cnt++;
    end
  endtask

  task automatic test_flatline();
    int bound;
    align_interval();
    step(1'b1, 8'h32, 1'b0, 2'($urandom_range(0, 3)));
    bound = 0;
    while (hist.size() < 3 && bound < 40) begin
      step(1'b0, 8'($urandom), 1'b0, 2'($urandom_range(0, 3)));
      total_cnt++;
      if (got_vec() !== want_vec()) $display("[TB] FAIL flatline_state: got %h, expected %h", got_vec(), want_vec());
      else pass_cnt++;
      bound++;
    end
    total_cnt++;
    if (sample_count !== 3'd3 || last_price !== 8'h32)
      $display("[TB] FAIL flatline_fill: got cnt=%0d last=%h, expected cnt=3 last=32", sample_count, last_price);
    else pass_cnt++;
    step(1'b0, 8'h00, 1'b0, 2'd1);
    total_cnt++;
    if (rd_data !== 8'h32) $display("[TB] FAIL flatline_read: got %h, expected 32", rd_data);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [7:0] want [4];
    want[0] = 8'h20; want[1] = 8'h30; want[2] = 8'h40; want[3] = 8'h50;
    for (int t = 1; t <= 5; t++) begin
      align_interval();
      step(1'b1, 8'(t * 16), 1'b0, 2'($urandom_range(0, 3)));
      for (int k = 0; k < 3; k++) begin
        step(1'b0, 8'($urandom), 1'b0, 2'($urandom_range(0, 3)));
        total_cnt++;
        if (got_vec() !== want_vec()) $display("[TB] FAIL wrap_state: got %h, expected %h", got_vec(), want_vec());
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (full !== 1'b1 || sample_count !== 3'd4)
      $display("[TB] FAIL wrap_full: got full=%b cnt=%0d, expected full=1 cnt=4", full, sample_count);
    else pass_cnt++;
    for (int a = 0; a < 4; a++) begin
      step(1'b0, 8'h00, 1'b0, 2'(a));
      total_cnt++;
      if (rd_data !== want[a]) $display("[TB] FAIL wrap_read%0d: got %h, expected %h", a, rd_data, want[a]);
      else pass_cnt++;
    end
  endtask

  task automatic test_collision();
    align_interval();
    step(1'b1, 8'h11, 1'b0, 2'd0);
    step(1'b0, 8'h00, 1'b0, 2'd0);
    step(1'b0, 8'h00, 1'b0, 2'd0);
    step(1'b1, 8'h77, 1'b0, 2'd0);
    total_cnt++;
    if (last_price !== 8'h77 || new_sample !== 1'b1)
      $display("[TB] FAIL collision_write: got last=%h new=%b, expected last=77 new=1", last_price, new_sample);
    else pass_cnt++;
    step(1'b0, 8'h00, 1'b0, 2'd3);
    total_cnt++;
    if (rd_data !== 8'h77) $display("[TB] FAIL collision_newest: got %h, expected 77", rd_data);
    else pass_cnt++;
    step(1'b0, 8'h00, 1'b0, 2'd0);
    step(1'b0, 8'h00, 1'b0, 2'd0);
    step(1'b0, 8'h00, 1'b0, 2'd0);
    total_cnt++;
    if (last_price !== 8'h77 || new_sample !== 1'b1)
      $display("[TB] FAIL collision_repeat: got last=%h new=%b, expected last=77 new=1", last_price, new_sample);
    else pass_cnt++;
    step(1'b0, 8'h00, 1'b0, 2'd2);
    total_cnt++;
    if (rd_data !== 8'h77) $display("[TB] FAIL collision_prev: got %h, expected 77", rd_data);
    else pass_cnt++;
  endtask

  task automatic test_halt();
    align_interval();
    for (int i = 0; i < 12; i++) begin
      step(i == 3, (i == 3) ? 8'h05 : 8'($urandom), 1'b1, 2'($urandom_range(0, 3)));
      total_cnt++;
      if (new_sample !== 1'b0 || last_price !== 8'h77)
        $display("[TB] FAIL halt_frozen: got new=%b last=%h, expected new=0 last=77", new_sample, last_price);
      else pass_cnt++;
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b0, 2'd0);
      total_cnt++;
      if (new_sample !== (i == 3) || last_price !== ((i == 3) ? 8'h05 : 8'h77))
        $display("[TB] FAIL halt_resume%0d: got new=%b last=%h, expected new=%b last=%h",
                 i, new_sample, last_price, i == 3, (i == 3) ? 8'h05 : 8'h77);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)));
      total_cnt++;
      if (got_vec() !== want_vec()) $display("[TB] FAIL random_state%0d: got %h, expected %h", i, got_vec(), want_vec());
      else pass_cnt++;
    end
  endtask

  task automatic test_minmax();
    logic [7:0] exp_lo, exp_hi, rst_lo;
`ifdef TRADE_HISTORY_MINMAX_EN
    exp_lo = 8'h10; exp_hi = 8'h90; rst_lo = 8'hFF;
`else
    exp_lo = 8'h00; exp_hi = 8'h00; rst_lo = 8'h00;
`endif
    @(negedge clk_50);
    #2 reset_n = 1'b0;
    #1 model_reset();
    @(negedge clk_50);
    reset_n = 1'b1;
    for (int s = 0; s < 3; s++) begin
      align_interval();
      step(1'b1, (s == 0) ? 8'h40 : (s == 1) ? 8'h10 : 8'h90, 1'b0, 2'd0);
      for (int k = 0; k < 3; k++) step(1'b0, 8'($urandom), 1'b0, 2'($urandom_range(0, 3)));
    end
    total_cnt++;
    if (min_price !== exp_lo || max_price !== exp_hi)
      $display("[TB] FAIL minmax_track: got min=%h max=%h, expected min=%h max=%h", min_price, max_price, exp_lo, exp_hi);
    else pass_cnt++;
    step(1'b1, 8'h99, 1'b0, 2'd0);
    step(1'b0, 8'h00, 1'b0, 2'd0);
    #2 reset_n = 1'b0;
    #1 model_reset();
    total_cnt++;
    if (min_price !== rst_lo || max_price !== 8'h00 || sample_count !== 3'd0 || full !== 1'b0 || last_price !== 8'h00)
      $display("[TB] FAIL async_reset: got min=%h max=%h cnt=%0d full=%b last=%h, expected min=%h max=00 cnt=0 full=0 last=00",
               min_price, max_price, sample_count, full, last_price, rst_lo);
    else pass_cnt++;
    @(negedge clk_50);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'($urandom), 1'b0, 2'($urandom_range(0, 3)));
      total_cnt++;
      if (new_sample !== 1'b0 || sample_count !== 3'd0)
        $display("[TB] FAIL post_reset_idle: got new=%b cnt=%0d, expected new=0 cnt=0", new_sample, sample_count);
      else pass_cnt++;
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    match_signal = 1'b0;
    trade_price  = 8'h00;
    halt_signal  = 1'b0;
    rd_addr      = '0;
    model_reset();
    test_reset();
    test_flatline();
    test_wrap();
    test_collision();
    test_halt();
    test_random();
    test_minmax();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
